// File: rtl/sargantana_icache_pkg.sv
// Shared types and geometry for the sargantana icache valid-bit control path.
package sargantana_icache_pkg;

  localparam int ICACHE_IDX_WIDTH = 6;
  localparam int ICACHE_N_WAY     = 4;
  localparam int ICACHE_N_SETS    = 2 ** ICACHE_IDX_WIDTH;

  typedef enum logic [1:0] {VC_IDLE, VC_FLUSH, VC_DONE} valid_ctrl_state_t;

endpackage

// File: rtl/sargantana_icache_valid_ctrl.sv
// Valid-bit array port sequencer: fixed-priority arbiter plus fence.i flush walk.
// Optional SARGANTANA_ICACHE_FLUSH_STATS_EN adds a saturating completed-flush counter.
//
// state    | meaning
// VC_IDLE  | arbitrate refill > flush start > inval > read
// VC_FLUSH | clear all ways of set r_cnt, one set per cycle
// VC_DONE  | one-cycle flush_ack_o, port idle
module sargantana_icache_valid_ctrl
  import sargantana_icache_pkg::*;
#(
  parameter int IDX_W = ICACHE_IDX_WIDTH,
  parameter int N_WAY = ICACHE_N_WAY,
  localparam int WAY_W = (N_WAY > 1) ? $clog2(N_WAY) : 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             flush_req_i,
  output logic             flush_ack_o,
  output logic             busy_o,
  input  logic             refill_req_i,
  input  logic [IDX_W-1:0] refill_idx_i,
  input  logic [WAY_W-1:0] refill_way_i,
  output logic             refill_gnt_o,
  input  logic             inval_req_i,
  input  logic [IDX_W-1:0] inval_idx_i,
  output logic             inval_gnt_o,
  input  logic             rd_req_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_gnt_o,
  output logic             vram_req_o,
  output logic             vram_we_o,
  output logic [IDX_W-1:0] vram_addr_o,
  output logic [N_WAY-1:0] vram_mask_o,
  output logic             vram_wdata_o
`ifdef SARGANTANA_ICACHE_FLUSH_STATS_EN
  ,
  output logic [31:0]      flush_cnt_o
`endif
);

  localparam int N_SETS = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SETS - 1);
  localparam logic [N_WAY-1:0] WAY_ONE  = N_WAY'(1);

  valid_ctrl_state_t r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_cnt, w_cnt_nxt;

  logic             w_flush_ack, w_refill_gnt, w_inval_gnt, w_rd_gnt;
  logic             w_req, w_we, w_wdata;
  logic [IDX_W-1:0] w_addr;
  logic [N_WAY-1:0] w_mask;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= VC_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_flush_ack  = 1'b0;
    w_refill_gnt = 1'b0;
    w_inval_gnt  = 1'b0;
    w_rd_gnt     = 1'b0;
    w_req        = 1'b0;
    w_we         = 1'b0;
    w_wdata      = 1'b0;
    w_addr       = '0;
    w_mask       = '0;
    case (r_state)
      VC_IDLE: begin
        if (refill_req_i) begin
          w_refill_gnt = 1'b1;
          w_req        = 1'b1;
          w_we         = 1'b1;
          w_wdata      = 1'b1;
          w_addr       = refill_idx_i;
          w_mask       = WAY_ONE << refill_way_i;
        end else if (flush_req_i) begin
          // The start cycle leaves the port idle so the walk begins cleanly at set 0.
          w_state_nxt = VC_FLUSH;
          w_cnt_nxt   = '0;
        end else if (inval_req_i) begin
          w_inval_gnt = 1'b1;
          w_req       = 1'b1;
          w_we        = 1'b1;
          w_addr      = inval_idx_i;
          w_mask      = '1;
        end else if (rd_req_i) begin
          w_rd_gnt = 1'b1;
          w_req    = 1'b1;
          w_addr   = rd_idx_i;
          w_mask   = '1;
        end
      end
      VC_FLUSH: begin
        w_req  = 1'b1;
        w_we   = 1'b1;
        w_addr = r_cnt;
        w_mask = '1;
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = VC_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + IDX_W'(1);
        end
      end
      VC_DONE: begin
        w_flush_ack = 1'b1;
        w_state_nxt = VC_IDLE;
      end
      default: w_state_nxt = VC_IDLE;
    endcase
  end

  // Outputs are forced low while reset is asserted, even with requests pending.
  assign flush_ack_o  = rstn_i & w_flush_ack;
  assign busy_o       = rstn_i & (r_state != VC_IDLE);
  assign refill_gnt_o = rstn_i & w_refill_gnt;
  assign inval_gnt_o  = rstn_i & w_inval_gnt;
  assign rd_gnt_o     = rstn_i & w_rd_gnt;
  assign vram_req_o   = rstn_i & w_req;
  assign vram_we_o    = rstn_i & w_we;
  assign vram_wdata_o = rstn_i & w_wdata;
  assign vram_addr_o  = rstn_i ? w_addr : '0;
  assign vram_mask_o  = rstn_i ? w_mask : '0;

`ifdef SARGANTANA_ICACHE_FLUSH_STATS_EN
  logic [31:0] r_flush_cnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_flush_cnt <= '0;
    end else if (w_flush_ack && (r_flush_cnt != '1)) begin
      r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign flush_cnt_o = r_flush_cnt;
`endif

endmodule

// File: tb/tb_sargantana_icache_valid_ctrl.sv
// Scoreboard bench for sargantana_icache_valid_ctrl (IDX_W=6, N_WAY=4).
module tb_sargantana_icache_valid_ctrl;
  import sargantana_icache_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic       flush_req, flush_ack, busy;
  logic       refill_req, refill_gnt;
  logic [5:0] refill_idx;
  logic [1:0] refill_way;
  logic       inval_req, inval_gnt;
  logic [5:0] inval_idx;
  logic       rd_req, rd_gnt;
  logic [5:0] rd_idx;
  logic       vram_req, vram_we, vram_wdata;
  logic [5:0] vram_addr;
  logic [3:0] vram_mask;
`ifdef SARGANTANA_ICACHE_FLUSH_STATS_EN
  logic [31:0] flush_cnt;
  int          exp_flushes = 0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [17:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  sargantana_icache_valid_ctrl #(.IDX_W(6), .N_WAY(4)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .flush_req_i  (flush_req),
    .flush_ack_o  (flush_ack),
    .busy_o       (busy),
    .refill_req_i (refill_req),
    .refill_idx_i (refill_idx),
    .refill_way_i (refill_way),
    .refill_gnt_o (refill_gnt),
    .inval_req_i  (inval_req),
    .inval_idx_i  (inval_idx),
    .inval_gnt_o  (inval_gnt),
    .rd_req_i     (rd_req),
    .rd_idx_i     (rd_idx),
    .rd_gnt_o     (rd_gnt),
    .vram_req_o   (vram_req),
    .vram_we_o    (vram_we),
    .vram_addr_o  (vram_addr),
    .vram_mask_o  (vram_mask),
    .vram_wdata_o (vram_wdata)
`ifdef SARGANTANA_ICACHE_FLUSH_STATS_EN
    ,
    .flush_cnt_o  (flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected word: {ack,busy,rgnt,igt,dgnt,req,we,wdata,mask[3:0],addr[5:0]}
  function automatic logic [17:0] mk(input logic ack, input logic bsy, input logic rg,
                                     input logic ig, input logic dg, input logic rq,
                                     input logic we, input logic wd, input logic [3:0] m,
                                     input logic [5:0] a);
    return {ack, bsy, rg, ig, dg, rq, we, wd, m, a};
  endfunction

  function automatic logic [17:0] e_idle();
    return '0;
  endfunction
  function automatic logic [17:0] e_flush(input int k);
    return mk(0, 1, 0, 0, 0, 1, 1, 0, 4'hF, 6'(k));
  endfunction
  function automatic logic [17:0] e_done();
    return mk(1, 1, 0, 0, 0, 0, 0, 0, 4'h0, 6'd0);
  endfunction
  function automatic logic [17:0] e_refill(input logic [5:0] idx, input logic [1:0] way);
    logic [3:0] m;
    m = 4'b0001 << way;
    return mk(0, 0, 1, 0, 0, 1, 1, 1, m, idx);
  endfunction
  function automatic logic [17:0] e_inval(input logic [5:0] idx);
    return mk(0, 0, 0, 1, 0, 1, 1, 0, 4'hF, idx);
  endfunction
  function automatic logic [17:0] e_rd(input logic [5:0] idx);
    return mk(0, 0, 0, 0, 1, 1, 0, 0, 4'hF, idx);
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [17:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, {14'd0, flush_ack, busy, refill_gnt, inval_gnt, rd_gnt, vram_req, vram_we,
              vram_wdata, vram_mask, vram_addr}, {14'd0, e});
    end
  end

  task automatic tick(input string tag, input logic [17:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // Runs the whole walk from the FLUSH-entry edge through the ack cycle.
  task automatic walk(input string tag, input bit drop_at_done);
    for (int k = 0; k < ICACHE_N_SETS; k++) tick({tag, "_walk"}, e_flush(k));
    if (drop_at_done) flush_req = 1'b0;
    tick({tag, "_ack"}, e_done());
`ifdef SARGANTANA_ICACHE_FLUSH_STATS_EN
    exp_flushes++;
`endif
  endtask

  task automatic chk_stats(input string tag);
`ifdef SARGANTANA_ICACHE_FLUSH_STATS_EN
    chk(tag, flush_cnt, 32'(exp_flushes));
`else
    if (tag.len() == 0) $display("empty stats tag");
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [17:0] e;
    logic rr, ir, dr;
    rstn = 1'b0;
    flush_req = 1'b0; refill_req = 1'b0; inval_req = 1'b0; rd_req = 1'b0;
    refill_idx = '0; refill_way = '0; inval_idx = '0; rd_idx = '0;
    @(posedge clk);
    #1;

    // Reset: outputs low even with requests pending.
    refill_req = 1'b1; refill_idx = 6'd7; flush_req = 1'b1; rd_req = 1'b1;
    tick("reset_gate", e_idle());
    tick("reset_gate", e_idle());
    refill_req = 1'b0; flush_req = 1'b0; rd_req = 1'b0;
    tick("reset_idle", e_idle());
    rstn = 1'b1;
    tick("post_reset", e_idle());
    chk_stats("stats_reset");

    // Priority among IDLE requesters with random indices.
    for (int i = 0; i < 16; i++) begin
      rr = 1'($urandom_range(0, 1)); ir = 1'($urandom_range(0, 1)); dr = 1'($urandom_range(0, 1));
      refill_req = rr; inval_req = ir; rd_req = dr;
      refill_idx = 6'($urandom); refill_way = 2'($urandom);
      inval_idx = 6'($urandom); rd_idx = 6'($urandom);
      if (rr)      e = e_refill(refill_idx, refill_way);
      else if (ir) e = e_inval(inval_idx);
      else if (dr) e = e_rd(rd_idx);
      else         e = e_idle();
      tick("prio", e);
    end
    refill_req = 1'b0; inval_req = 1'b0; rd_req = 1'b0;

    // 1: plain flush.
    flush_req = 1'b1;
    tick("f1_start", e_idle());
    walk("f1", 1'b1);
    tick("f1_idle", e_idle());
    chk_stats("stats_f1");

    // 2: refill wins over a simultaneous flush request.
    refill_req = 1'b1; refill_idx = 6'd5; refill_way = 2'd2; flush_req = 1'b1;
    tick("col_refill", e_refill(6'd5, 2'd2));
    refill_req = 1'b0;
    tick("col_start", e_idle());
    walk("col", 1'b1);
    tick("col_idle", e_idle());

    // 3: inval and read starve during the walk, then drain in priority order.
    flush_req = 1'b1;
    inval_req = 1'b1; inval_idx = 6'd9; rd_req = 1'b1; rd_idx = 6'd12;
    tick("stv_start", e_idle());
    walk("stv", 1'b1);
    tick("stv_inval", e_inval(6'd9));
    inval_req = 1'b0;
    tick("stv_rd", e_rd(6'd12));
    rd_req = 1'b0;
    tick("stv_idle", e_idle());
    chk_stats("stats_three");

    // 4: reset at cnt=30 aborts the walk; the next flush restarts at set 0.
    flush_req = 1'b1;
    tick("rst_start", e_idle());
    for (int k = 0; k < 30; k++) tick("rst_walk", e_flush(k));
    rstn = 1'b0;
`ifdef SARGANTANA_ICACHE_FLUSH_STATS_EN
    exp_flushes = 0;
`endif
    tick("rst_abort", e_idle());
    tick("rst_abort", e_idle());
    chk_stats("stats_abort");
    rstn = 1'b1;
    tick("rst_restart", e_idle());
    walk("rst", 1'b1);
    tick("rst_idle", e_idle());
    chk_stats("stats_restart");

    // 5: request held through the ack yields one IDLE cycle and a second walk.
    flush_req = 1'b1;
    tick("b2b_start", e_idle());
    walk("b2b_a", 1'b0);
    tick("b2b_gap", e_idle());
    walk("b2b_b", 1'b1);
    tick("b2b_idle", e_idle());
    chk_stats("stats_b2b");

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
